regfile_access_ctrl: RTL and testbench

//  Initiator side of the 16-entry register file port: owns rd1/rd2 address, write address/data, write enable.

---
 rtl/regfile_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register file access controller: operand reads for decode plus
// buffered writebacks, arbitrated so reads observe earlier writes.
module regfile_access_ctrl #(
  parameter int REG_WIDTH     = 16,
  parameter int WB_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_1_rd_req_valid,
  output logic                 o_1_rd_req_ready,
  input  logic [3:0]           i_4_rs1,
  input  logic [3:0]           i_4_rs2,
  output logic                 o_1_opnd_valid,
  input  logic                 i_1_opnd_ready,
  output logic [REG_WIDTH-1:0] o_R_opnd1,
  output logic [REG_WIDTH-1:0] o_R_opnd2,
  input  logic                 i_1_wb_valid,
  output logic                 o_1_wb_ready,
  input  logic [3:0]           i_4_wb_addr,
  input  logic [REG_WIDTH-1:0] i_R_wb_data,
  output logic [3:0]           o_4_rd1_addr,
  output logic [3:0]           o_4_rd2_addr,
  output logic [3:0]           o_4_wr_addr,
  output logic [REG_WIDTH-1:0] o_R_wr_data,
  output logic                 o_1_reg_wr_en,
  input  logic [REG_WIDTH-1:0] i_R_rd1_data,
  input  logic [REG_WIDTH-1:0] i_R_rd2_data
);

  localparam int AW = $clog2(WB_FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    OPND_HOLD
  } state_t;

  state_t state;

  logic [3:0]           rs1_q;
  logic [3:0]           rs2_q;
  logic [3:0]           fifo_addr [WB_FIFO_DEPTH];
  logic [REG_WIDTH-1:0] fifo_data [WB_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic fifo_empty;
  logic push;
  logic pop;
  logic drain_slot;
  logic rd_accept;

  assign fifo_empty = (count == '0);
  assign o_1_wb_ready = (count < CW'(WB_FIFO_DEPTH));

  // Writes to r15 (PC) are accepted but never queued.
  assign push = i_1_wb_valid & o_1_wb_ready
              & (i_4_wb_addr != 4'hF);

  assign drain_slot = (state == IDLE)
                    | (state == OPND_HOLD);
  assign pop = drain_slot & ~fifo_empty;

  // A read only goes out once nothing is pending or arriving.
  assign o_1_rd_req_ready = (state == IDLE) & fifo_empty
                          & ~i_1_wb_valid;
  assign rd_accept = i_1_rd_req_valid & o_1_rd_req_ready;

  assign o_1_reg_wr_en = pop;
  assign o_4_wr_addr   = pop ? fifo_addr[rd_ptr] : '0;
  assign o_R_wr_data   = pop ? fifo_data[rd_ptr] : '0;
  assign o_4_rd1_addr  = rs1_q;
  assign o_4_rd2_addr  = rs2_q;

  // Read sequencing and operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rs1_q          <= '0;
      rs2_q          <= '0;
      o_1_opnd_valid <= 1'b0;
      o_R_opnd1      <= '0;
      o_R_opnd2      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_accept) begin
            rs1_q <= i_4_rs1;
            rs2_q <= i_4_rs2;
            state <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          o_R_opnd1      <= i_R_rd1_data;
          o_R_opnd2      <= i_R_rd2_data;
          o_1_opnd_valid <= 1'b1;
          state          <= OPND_HOLD;
        end
        OPND_HOLD: begin
          if (i_1_opnd_ready) begin
            o_1_opnd_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_4_wb_addr;
      fifo_data[wr_ptr] <= i_R_wb_data;
    end
  end

  // Writeback FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: register file model, directed
// scenarios, random traffic and a scoreboard-based monitor.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_1_rd_req_valid = 1'b0;
  logic        o_1_rd_req_ready;
  logic [3:0]  i_4_rs1 = '0;
  logic [3:0]  i_4_rs2 = '0;
  logic        o_1_opnd_valid;
  logic        i_1_opnd_ready = 1'b0;
  logic [15:0] o_R_opnd1;
  logic [15:0] o_R_opnd2;
  logic        i_1_wb_valid = 1'b0;
  logic        o_1_wb_ready;
  logic [3:0]  i_4_wb_addr = '0;
  logic [15:0] i_R_wb_data = '0;
  logic [3:0]  o_4_rd1_addr;
  logic [3:0]  o_4_rd2_addr;
  logic [3:0]  o_4_wr_addr;
  logic [15:0] o_R_wr_data;
  logic        o_1_reg_wr_en;
  logic [15:0] i_R_rd1_data;
  logic [15:0] i_R_rd2_data;

  always #5 clk = ~clk;

  regfile_access_ctrl #(
    .REG_WIDTH(16),
    .WB_FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_1_rd_req_valid(i_1_rd_req_valid),
    .o_1_rd_req_ready(o_1_rd_req_ready),
    .i_4_rs1(i_4_rs1),
    .i_4_rs2(i_4_rs2),
    .o_1_opnd_valid(o_1_opnd_valid),
    .i_1_opnd_ready(i_1_opnd_ready),
    .o_R_opnd1(o_R_opnd1),
    .o_R_opnd2(o_R_opnd2),
    .i_1_wb_valid(i_1_wb_valid),
    .o_1_wb_ready(o_1_wb_ready),
    .i_4_wb_addr(i_4_wb_addr),
    .i_R_wb_data(i_R_wb_data),
    .o_4_rd1_addr(o_4_rd1_addr),
    .o_4_rd2_addr(o_4_rd2_addr),
    .o_4_wr_addr(o_4_wr_addr),
    .o_R_wr_data(o_R_wr_data),
    .o_1_reg_wr_en(o_1_reg_wr_en),
    .i_R_rd1_data(i_R_rd1_data),
    .i_R_rd2_data(i_R_rd2_data)
  );

  function automatic logic [15:0] init_val(input int i);
    case (i)
      2, 3:    return 16'h0001;
      13:      return 16'h00A0;
      15:      return 16'h0042;
      default: return 16'h0000;
    endcase
  endfunction

  // Team register file: r15 returns PC+, reads only when not writing.
  logic [15:0] rf [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
      i_R_rd1_data <= '0;
      i_R_rd2_data <= '0;
    end else if (o_1_reg_wr_en) begin
      if (o_4_wr_addr != 4'hF) rf[o_4_wr_addr] <= o_R_wr_data;
    end else begin
      i_R_rd1_data <= rf[o_4_rd1_addr];
      i_R_rd2_data <= rf[o_4_rd2_addr];
    end
  end

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;
  typedef struct {
    logic [15:0] o1;
    logic [15:0] o2;
  } op_t;

  wr_t         wq[$];
  op_t         opq[$];
  logic [15:0] arch [16];
  wr_t         we;
  op_t         oe;
  int          ncmp = 0;
  int          nbad = 0;
  int          cyc = 0;
  int          acc_cyc = -100;
  bit          prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: architectural model plus queues of expected writes/operands.
  always @(negedge clk) begin
    if (rst) begin
      wq.delete();
      opq.delete();
      for (int i = 0; i < 16; i++) arch[i] = init_val(i);
      acc_cyc = -100;
      prev_v = 1'b0;
    end else begin
      chk("wb_ready", 32'(o_1_wb_ready), 32'(wq.size() < 4));
      if (o_1_reg_wr_en) begin
        if (wq.size() == 0) begin
          ncmp++;
          nbad++;
          $display("FAIL wr_unexp: got write r%0d=%h expected none",
                   o_4_wr_addr, o_R_wr_data);
        end else begin
          we = wq.pop_front();
          chk("wr_addr", 32'(o_4_wr_addr), 32'(we.a));
          chk("wr_data", 32'(o_R_wr_data), 32'(we.d));
          arch[we.a] = we.d;
        end
      end
      if (cyc == acc_cyc + 1 || cyc == acc_cyc + 2)
        chk("wr_supp", 32'(o_1_reg_wr_en), 32'd0);
      if (o_1_rd_req_ready)
        chk("rd_order", 32'(wq.size() == 0 && !i_1_wb_valid), 32'd1);
      if (i_1_rd_req_valid && o_1_rd_req_ready) begin
        oe.o1 = arch[i_4_rs1];
        oe.o2 = arch[i_4_rs2];
        opq.push_back(oe);
        acc_cyc = cyc;
      end
      if (i_1_wb_valid && o_1_wb_ready && i_4_wb_addr != 4'hF) begin
        we.a = i_4_wb_addr;
        we.d = i_R_wb_data;
        wq.push_back(we);
      end
      if (o_1_opnd_valid && !prev_v)
        chk("opnd_lat", 32'(cyc - acc_cyc), 32'd3);
      if (o_1_opnd_valid && i_1_opnd_ready) begin
        if (opq.size() == 0) begin
          ncmp++;
          nbad++;
          $display("FAIL opnd_unexp: got %h/%h expected none",
                   o_R_opnd1, o_R_opnd2);
        end else begin
          oe = opq.pop_front();
          chk("opnd1", 32'(o_R_opnd1), 32'(oe.o1));
          chk("opnd2", 32'(o_R_opnd2), 32'(oe.o2));
        end
      end
      prev_v = o_1_opnd_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] b);
    i_1_rd_req_valid = 1'b1;
    i_4_rs1 = a;
    i_4_rs2 = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_1_rd_req_ready) begin
        tick();
        i_1_rd_req_valid = 1'b0;
        return;
      end
      tick();
    end
    ncmp++;
    nbad++;
    $display("FAIL rd_timeout: got no ready expected accept");
    i_1_rd_req_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [3:0] a, input logic [15:0] d);
    i_1_wb_valid = 1'b1;
    i_4_wb_addr = a;
    i_R_wb_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_1_wb_ready) begin
        tick();
        i_1_wb_valid = 1'b0;
        return;
      end
      tick();
    end
    ncmp++;
    nbad++;
    $display("FAIL wb_timeout: got no ready expected accept");
    i_1_wb_valid = 1'b0;
  endtask

  task automatic get_opnd(input int hold, output logic [15:0] o1,
                          output logic [15:0] o2);
    bit got = 1'b0;
    o1 = '0;
    o2 = '0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = o_1_opnd_valid;
    end
    if (!got) begin
      ncmp++;
      nbad++;
      $display("FAIL opnd_timeout: got no valid expected operands");
      tick();
      return;
    end
    tick();
    repeat (hold) tick();
    i_1_opnd_ready = 1'b1;
    @(negedge clk);
    chk("opnd_held", 32'(o_1_opnd_valid), 32'd1);
    o1 = o_R_opnd1;
    o2 = o_R_opnd2;
    tick();
    i_1_opnd_ready = 1'b0;
  endtask

  logic [15:0] r1, r2;

  initial begin
    // Reset held two cycles: every output quiet.
    tick();
    tick();
    @(negedge clk);
    chk("rst_opnd_valid", 32'(o_1_opnd_valid), 32'd0);
    chk("rst_opnd1", 32'(o_R_opnd1), 32'd0);
    chk("rst_opnd2", 32'(o_R_opnd2), 32'd0);
    chk("rst_wr_en", 32'(o_1_reg_wr_en), 32'd0);
    chk("rst_rd1_addr", 32'(o_4_rd1_addr), 32'd0);
    chk("rst_rd2_addr", 32'(o_4_rd2_addr), 32'd0);
    chk("rst_wr_addr", 32'(o_4_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(o_R_wr_data), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rd_ready", 32'(o_1_rd_req_ready), 32'd1);
    chk("post_wb_ready", 32'(o_1_wb_ready), 32'd1);
    tick();

    // Plain read of reset values, held for a while before taking.
    do_read(4'd2, 4'd13);
    get_opnd(3, r1, r2);
    chk("t2_opnd1", 32'(r1), 32'h0001);
    chk("t2_opnd2", 32'(r2), 32'h00A0);

    // Write and read in the same cycle: read waits for the write.
    i_1_wb_valid = 1'b1;
    i_4_wb_addr = 4'd4;
    i_R_wb_data = 16'h1234;
    i_1_rd_req_valid = 1'b1;
    i_4_rs1 = 4'd4;
    i_4_rs2 = 4'd3;
    @(negedge clk);
    chk("t3_stall", 32'(o_1_rd_req_ready), 32'd0);
    tick();
    i_1_wb_valid = 1'b0;
    do_read(4'd4, 4'd3);
    get_opnd(0, r1, r2);
    chk("t3_opnd1", 32'(r1), 32'h1234);
    chk("t3_opnd2", 32'(r2), 32'h0001);

    // Five back-to-back writebacks, then read them all back.
    for (int i = 5; i <= 9; i++) do_wb(4'(i), 16'hA500 + 16'(i));
    do_read(4'd5, 4'd6);
    get_opnd(0, r1, r2);
    chk("t4_r5", 32'(r1), 32'hA505);
    chk("t4_r6", 32'(r2), 32'hA506);
    do_read(4'd7, 4'd8);
    get_opnd(1, r1, r2);
    chk("t4_r7", 32'(r1), 32'hA507);
    chk("t4_r8", 32'(r2), 32'hA508);
    do_read(4'd9, 4'd4);
    get_opnd(0, r1, r2);
    chk("t4_r9", 32'(r1), 32'hA509);
    chk("t4_r4", 32'(r2), 32'h1234);

    // Writes to r15 are swallowed; r15 reads return PC+.
    do_wb(4'd15, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_wr", 32'(o_1_reg_wr_en), 32'd0);
      tick();
    end
    do_read(4'd15, 4'd2);
    get_opnd(0, r1, r2);
    chk("t5_pc", 32'(r1), 32'h0042);
    chk("t5_r2", 32'(r2), 32'h0001);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      i_1_rd_req_valid = 1'($urandom_range(0, 1));
      i_4_rs1 = 4'($urandom_range(0, 15));
      i_4_rs2 = 4'($urandom_range(0, 15));
      i_1_wb_valid = ($urandom_range(0, 2) == 0);
      i_4_wb_addr = 4'($urandom_range(0, 15));
      i_R_wb_data = 16'($urandom);
      i_1_opnd_ready = 1'($urandom_range(0, 1));
      tick();
    end
    i_1_rd_req_valid = 1'b0;
    i_1_wb_valid = 1'b0;
    i_1_opnd_ready = 1'b1;
    repeat (10) tick();
    i_1_opnd_ready = 1'b0;

    // Reset mid-read with writes queued: everything is dropped.
    do_read(4'd6, 4'd13);
    i_1_wb_valid = 1'b1;
    i_4_wb_addr = 4'd6;
    i_R_wb_data = 16'h5555;
    tick();
    i_4_wb_addr = 4'd7;
    i_R_wb_data = 16'h7777;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_opnd_valid", 32'(o_1_opnd_valid), 32'd0);
    chk("t6_wr_en", 32'(o_1_reg_wr_en), 32'd0);
    tick();
    i_1_wb_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_wr", 32'(o_1_reg_wr_en), 32'd0);
      tick();
    end
    do_read(4'd6, 4'd7);
    get_opnd(0, r1, r2);
    chk("t6_r6_lost", 32'(r1), 32'h0000);
    chk("t6_r7_lost", 32'(r2), 32'h0000);

    repeat (4) tick();
    chk("wq_left", 32'(wq.size()), 32'd0);
    chk("opq_left", 32'(opq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
